uart_receiver: RTL and testbench

- UART receive end: deserialises an asynchronous serial line into parallel bytes.
- Frame format: 1 start bit (0), DATA_BITS data bits LSB first, optional parity bit, 1 stop bit (1).
- Frame format and bit order match the transmitter's start/data/parity/stop serial sequence, so the pair forms a loopback-capable link.
- Sits at the chip pin side of the UART, feeding received bytes and error flags to the host/register logic.

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_baud_tick.sv | 15 +
 rtl/uart_receiver.sv | 82 ++++++++
 tb/tb_uart_receiver.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding and oversampled bit-timing constants shared across the UART.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_t;
  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_A = 7;
  localparam int SAMPLE_B = 8;
  localparam int SAMPLE_C = 9;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: divides clk by BAUD_DIV into a one-cycle oversample tick, held cleared while clr.
module uart_baud_tick #(
  parameter int BAUD_DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  logic [15:0] cnt;
  assign tick = !clr && cnt == 16'(BAUD_DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clr || tick) ? 16'd0 : cnt + 16'd1;
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 16x oversampled UART receive path with majority-vote sampling,
// parity and framing checks, and break suppression.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 27,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);
  state_t state, state_n;
  logic rx_m, rxs, tick, maj, decide, bit_end, perr;
  logic [3:0] os_cnt;
  logic [2:0] bit_idx;
  logic [1:0] smp;
  logic [DATA_BITS-1:0] shreg;
  uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state == IDLE),
    .tick (tick)
  );
  assign maj     = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);
  assign decide  = tick && os_cnt == 4'(SAMPLE_C);
  assign bit_end = tick && os_cnt == 4'(OVERSAMPLE - 1);
  assign busy    = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:       state_n = rxs ? IDLE : START;
      START:      state_n = (decide && maj) ? IDLE : bit_end ? DATA : START;
      DATA:       state_n = (bit_end && bit_idx == 3'(DATA_BITS - 1)) ? ((PARITY_EN != 0) ? PARITY : STOP) : DATA;
      PARITY:     state_n = bit_end ? STOP : PARITY;
      STOP:       state_n = decide ? (maj ? IDLE : BREAK_WAIT) : STOP;
      BREAK_WAIT: state_n = rxs ? IDLE : BREAK_WAIT;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m       <= 1'b1;
      rxs        <= 1'b1;
      state      <= IDLE;
      os_cnt     <= '0;
      bit_idx    <= '0;
      smp        <= '0;
      shreg      <= '0;
      perr       <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_m     <= rx;
      rxs      <= rx_m;
      state    <= state_n;
      rx_valid <= 1'b0;
      os_cnt   <= (state == IDLE) ? 4'd0 : tick ? os_cnt + 4'd1 : os_cnt;
      if (tick && os_cnt == 4'(SAMPLE_A)) smp[0] <= rxs;
      if (tick && os_cnt == 4'(SAMPLE_B)) smp[1] <= rxs;
      bit_idx <= (state == START) ? 3'd0 : (state == DATA && bit_end) ? bit_idx + 3'd1 : bit_idx;
      if (state == DATA && decide) shreg <= {maj, shreg[DATA_BITS-1:1]};
      if (state == PARITY && decide) perr <= (^shreg ^ maj) != (PARITY_ODD != 0);
      // data and both flags are published together on the stop-bit decision
      if (state == STOP && decide) begin
        rx_valid   <= 1'b1;
        rx_data    <= shreg;
        parity_err <= (PARITY_EN != 0) && perr;
        frame_err  <= ~maj;
      end
    end
  end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scoreboard bench driving a parity (even) receiver and a no-parity receiver.
module tb_uart_receiver;
  localparam int BD = 2;
  localparam int BIT_CLKS = 16 * BD;
  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;
  logic clk = 0, rst_n = 0, rx0 = 1, rx1 = 1;
  logic [7:0] d0, d1;
  logic v0, v1, pe0, pe1, fe0, fe1, b0, b1;
  int checks = 0, errors = 0;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
  always #5 clk = ~clk;
  uart_receiver #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx0), .rx_data(d0), .rx_valid(v0),
    .parity_err(pe0), .frame_err(fe0), .busy(b0)
  );
  uart_receiver #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_np (
    .clk(clk), .rst_n(rst_n), .rx(rx1), .rx_data(d1), .rx_valid(v1),
    .parity_err(pe1), .frame_err(fe1), .busy(b1)
  );
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input int w, input logic b);
    if (w == 0) rx0 = b; else rx1 = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask
  task automatic idle(input int w, input int n);
    for (int i = 0; i < n; i++) drive(w, 1'b1);
  endtask
  // reference: a frame reports its data, a parity error iff the sent parity bit was wrong, a frame error iff stop was 0
  task automatic send(input int w, input logic [7:0] d, input logic flip, input logic stop);
    exp_t e;
    e.d = d;
    e.pe = (w == 0) ? flip : 1'b0;
    e.fe = !stop;
    if (w == 0) q0.push_back(e); else q1.push_back(e);
    drive(w, 1'b0);
    for (int i = 0; i < 8; i++) drive(w, d[i]);
    if (w == 0) drive(w, (^d) ^ flip);
    drive(w, stop);
  endtask
  always @(negedge clk)
    if (rst_n && v0) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid0: rx_data=%0h frame_err=%0b with no frame expected", d0, fe0);
      end else begin
        e0 = q0.pop_front();
        chk("data0", d0, e0.d);
        chk("perr0", 8'(pe0), 8'(e0.pe));
        chk("ferr0", 8'(fe0), 8'(e0.fe));
      end
    end
  always @(negedge clk)
    if (rst_n && v1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid1: rx_data=%0h frame_err=%0b with no frame expected", d1, fe1);
      end else begin
        e1 = q1.pop_front();
        chk("data1", d1, e1.d);
        chk("perr1", 8'(pe1), 8'(e1.pe));
        chk("ferr1", 8'(fe1), 8'(e1.fe));
      end
    end
  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
  initial begin
    logic [7:0] d;
    logic flip, stop;
    int w;
    repeat (3) @(negedge clk);
    chk("rst_data", d0, 8'h00);
    chk("rst_valid", 8'(v0), 8'h00);
    chk("rst_perr", 8'(pe0), 8'h00);
    chk("rst_ferr", 8'(fe0), 8'h00);
    chk("rst_busy", 8'(b0), 8'h00);
    rst_n = 1;
    idle(0, 2);
    send(0, 8'hA5, 1'b0, 1'b1);
    idle(0, 1);
    chk("busy_after_frame", 8'(b0), 8'h00);
    send(0, 8'hA5, 1'b1, 1'b1);
    idle(0, 2);
    send(0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) drive(0, 1'b0);
    idle(0, 4);
    send(0, 8'h3C, 1'b0, 1'b1);
    idle(0, 2);
    rx0 = 0;
    repeat (4) @(negedge clk);
    chk("glitch_busy_high", 8'(b0), 8'h01);
    repeat (4) @(negedge clk);
    rx0 = 1;
    repeat (BIT_CLKS) @(negedge clk);
    chk("glitch_busy_low", 8'(b0), 8'h00);
    idle(1, 2);
    send(1, 8'h00, 1'b0, 1'b1);
    send(1, 8'hFF, 1'b0, 1'b1);
    send(1, 8'h55, 1'b0, 1'b1);
    idle(1, 2);
    d = 8'h6B;
    drive(0, 1'b0);
    for (int i = 0; i < 4; i++) drive(0, d[i]);
    rx0 = d[4];
    repeat (10) @(negedge clk);
    rst_n = 0;
    rx0 = 1;
    @(negedge clk);
    chk("midrst_data", d0, 8'h00);
    chk("midrst_valid", 8'(v0), 8'h00);
    chk("midrst_perr", 8'(pe0), 8'h00);
    chk("midrst_ferr", 8'(fe0), 8'h00);
    chk("midrst_busy", 8'(b0), 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1;
    idle(0, 2);
    send(0, 8'h81, 1'b0, 1'b1);
    idle(0, 1);
    for (int n = 0; n < 16; n++) begin
      w = int'($urandom_range(0, 1));
      d = 8'($urandom);
      flip = 1'($urandom_range(0, 1));
      stop = $urandom_range(0, 7) != 0;
      send(w, d, flip, stop);
      if (!stop || $urandom_range(0, 1) == 1) idle(w, int'($urandom_range(1, 2)));
    end
    idle(0, 3);
    idle(1, 1);
    chk("q0_drained", 8'(q0.size()), 8'h00);
    chk("q1_drained", 8'(q1.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
